fifo_rd_ctrl: RTL
=================

// Module: fifo_rd_ctrl
// PURPOSE
//  Read-domain controller for the asynchronous FIFO; parametrised successor of the original read controller.
//  Synchronises the Gray write pointer into rclk and owns the read pointer (binary + registered Gray for the write side).
//  Drives the dual-port RAM read address and captures read data.
//  Adds fill level, almost-empty, underflow flag, configurable sync depth and optional FWFT output stage.
// PARAMETERS
//  PTRWIDTH     4   address bits; depth = 2**PTRWIDTH; pointers are PTRWIDTH+1 bits (wrap bit)
//  SYNC_STAGES  2   flops in the wrptr_gray synchroniser; legal 2..4
//  AE_THRESH    2   almost_empty asserted when fill level <= AE_THRESH; legal 0..2**PTRWIDTH
//  DWIDTH       8   data width
// PORTS
//  rclk          in   1           read clock; sole clock
//  reset         in   1           asynchronous, active-high reset
//  pop           in   1           read request
//  wrptr_gray    in   PTRWIDTH+1  write pointer, Gray, from wclk domain
//  mem_rdata     in   DWIDTH      RAM read data; combinational read of rd_addr
//  rd_addr       out  PTRWIDTH    RAM read address = rdptr_bin[PTRWIDTH-1:0]
//  rd_en         out  1           RAM read strobe (word consumed this cycle)
//  dout          out  DWIDTH      registered read data
//  rdptr_gray    out  PTRWIDTH+1  registered Gray read pointer, to wclk domain
//  empty         out  1           no data available to pop
//  almost_empty  out  1           fill level <= AE_THRESH
//  rd_count      out  PTRWIDTH+1  fill level as seen in rclk domain, 0..2**PTRWIDTH
//  underflow     out  1           registered 1-cycle pulse: pop while empty
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers, sync chain, dout, underflow = 0; empty = 1; almost_empty = 1; rd_count = 0.
//  - Reset mid-operation: all state returns to reset values immediately; no partial pop is kept.
//  - Sync chain: SYNC_STAGES flops, reset 0; wrptr_s = last stage.
//  - wrptr_bin = gray2bin(wrptr_s): MSB copied; bit i = bin[i+1] ^ gray[i] for every i down to 0.
//  - ram_count = (wrptr_bin - rdptr_bin) mod 2**(PTRWIDTH+1); combinational from flops.
//  - ram_empty = (ram_count == 0).
//  - rd_en = pop & ~ram_empty (standard mode); combinational.
//  - On rd_en: rdptr_bin <= rdptr_bin+1, with the carry out of PTRWIDTH+1 bits discarded (31 -> 0 for PTRWIDTH=4).
//    rdptr_gray <= bin2gray(rdptr_bin+1) in the same edge, so it is never derived combinationally.
//  - Standard mode: dout <= mem_rdata on rd_en (1-cycle latency pop->dout); dout holds otherwise.
//    empty = ram_empty; rd_count = ram_count.
//  - almost_empty = (rd_count <= AE_THRESH), combinational.
//  - Underflow: pop & empty -> underflow = 1 for exactly the next cycle; pointers and dout unchanged.
//  - Latency: a write is visible to empty/rd_count SYNC_STAGES rclk edges after wrptr_gray changes.
//    Flags are pessimistic only: empty may assert late-release, never early.
//  - Full-level: rd_count = 2**PTRWIDTH when the wrap bits differ and the lower bits are equal.
// CONFIGURATION
//  FIFO_RD_FWFT_EN defined: first-word-fall-through output stage.
//   - Internal dout_valid flop, reset 0.
//   - rd_en = ~ram_empty & (~dout_valid | pop); rd_en loads dout <= mem_rdata and sets dout_valid.
//   - pop & dout_valid & ~rd_en clears dout_valid.
//   - empty = ~dout_valid; rd_count = ram_count + dout_valid; underflow = pop & ~dout_valid.
//   - First word appears on dout one cycle after ram_empty falls, with no pop required.
//  FIFO_RD_FWFT_EN undefined: standard mode as described in BEHAVIOUR; no dout_valid flop.
// TESTING (PTRWIDTH=4, SYNC_STAGES=2, AE_THRESH=2 unless noted)
//  1. Reset asserted mid-stream with 5 words queued -> same cycle: empty=1, rd_count=0,
//     rdptr_gray=0, underflow=0; after release, pops give underflow pulses only.
//  2. wrptr_gray 0->00001->00011->00010 (3 words) -> empty falls 2 edges after first change;
//     rd_count reaches 3; almost_empty=0 only once rd_count=3.
//  3. Words A,B,C at addr 0..2; pop 3 cycles -> rd_addr 0,1,2; dout A,B,C one cycle after each pop;
//     empty=1 after third; rdptr_gray=00010.
//  4. Wrap: 40 write/read pairs -> rdptr_bin 31->0, rdptr_gray 10000->00000, rd_count never > 16, data in order;
//     write-only run to 16 -> rd_count=16.
//  5. pop=1 two cycles while empty -> underflow high two cycles, one cycle late; rdptr and dout unchanged.
//  6. FIFO_RD_FWFT_EN: one word X written, no pop -> dout=X, empty=0 at sync+1 edges;
//     pop -> empty=1 next cycle, rd_count 1->0; back-to-back pops stream with no bubble.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - async FIFO read-domain controller; FIFO_RD_FWFT_EN selects first-word-fall-through output
module fifo_rd_ctrl #(
  parameter int PTRWIDTH    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2,
  parameter int DWIDTH      = 8
) (
  input  logic                rclk,
  input  logic                reset,
  input  logic                pop,
  input  logic [PTRWIDTH:0]   wrptr_gray,
  input  logic [DWIDTH-1:0]   mem_rdata,
  output logic [PTRWIDTH-1:0] rd_addr,
  output logic                rd_en,
  output logic [DWIDTH-1:0]   dout,
  output logic [PTRWIDTH:0]   rdptr_gray,
  output logic                empty,
  output logic                almost_empty,
  output logic [PTRWIDTH:0]   rd_count,
  output logic                underflow
);

  localparam logic [PTRWIDTH:0] AE_LIMIT = AE_THRESH[PTRWIDTH:0];
  localparam logic [PTRWIDTH:0] PTR_ONE  = {{PTRWIDTH{1'b0}}, 1'b1};

  logic [PTRWIDTH:0] sync_q [SYNC_STAGES];
  logic [PTRWIDTH:0] wrptr_s;
  logic [PTRWIDTH:0] wrptr_bin;
  logic [PTRWIDTH:0] rdptr_bin;
  logic [PTRWIDTH:0] rdptr_nxt;
  logic [PTRWIDTH:0] ram_count;
  logic              ram_empty;

  function automatic logic [PTRWIDTH:0] gray2bin(input logic [PTRWIDTH:0] g);
    logic [PTRWIDTH:0] b;
    b[PTRWIDTH] = g[PTRWIDTH];
    for (int i = PTRWIDTH - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= wrptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wrptr_s   = sync_q[SYNC_STAGES-1];
  assign wrptr_bin = gray2bin(wrptr_s);
  assign ram_count = wrptr_bin - rdptr_bin;
  assign ram_empty = (ram_count == '0);
  assign rdptr_nxt = rdptr_bin + PTR_ONE;
  assign rd_addr   = rdptr_bin[PTRWIDTH-1:0];

  // Gray pointer is registered alongside the binary one so the write side never sees a glitch.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      rdptr_bin  <= '0;
      rdptr_gray <= '0;
    end else if (rd_en) begin
      rdptr_bin  <= rdptr_nxt;
      rdptr_gray <= rdptr_nxt ^ (rdptr_nxt >> 1);
    end
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      dout <= '0;
    end else if (rd_en) begin
      dout <= mem_rdata;
    end
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      underflow <= 1'b0;
    end else begin
      underflow <= pop & empty;
    end
  end

`ifdef FIFO_RD_FWFT_EN
  logic dout_valid;

  // The output register is refilled whenever it is free or being consumed.
  assign rd_en    = ~ram_empty & (~dout_valid | pop);
  assign empty    = ~dout_valid;
  assign rd_count = ram_count + {{PTRWIDTH{1'b0}}, dout_valid};

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      dout_valid <= 1'b0;
    end else if (rd_en) begin
      dout_valid <= 1'b1;
    end else if (pop & dout_valid) begin
      dout_valid <= 1'b0;
    end
  end
`else
  assign rd_en    = pop & ~ram_empty;
  assign empty    = ram_empty;
  assign rd_count = ram_count;
`endif

  assign almost_empty = (rd_count <= AE_LIMIT);

endmodule
